// File: rtl/mult_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : mult_accumulator
//  Purpose  : Sums COUNT consecutive unsigned products taken over a
//             valid/ready handshake and presents each batch sum on a held
//             output handshake (sum-of-products stage behind the 4x4
//             array multiplier).
//  Option   : MULT_ACCUMULATOR_SAT_EN - saturate at 2^ACC_W-1 instead of
//             wrapping; out_ovf is flagged in both builds.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 10,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  localparam int              CNT_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               out_valid_q;
  logic [ACC_W-1:0]   out_acc_q;
  logic               out_ovf_q;

  logic [ACC_W:0]     sum_ext;
  logic               carry;
  logic [ACC_W-1:0]   acc_d;
  logic               ovf_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               xfer;

  // Handshake: beats are only taken while gathering and not being cleared.
  assign in_ready = (state_q == ST_ACC) && !clear;
  assign xfer     = in_valid && in_ready;

  // Next accumulator value: one extra bit captures the carry out of the MSB.
  always_comb begin
    sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    carry   = sum_ext[ACC_W];
    ovf_d   = ovf_q | carry;
    cnt_d   = cnt_q + CNT_W'(1);
`ifdef MULT_ACCUMULATOR_SAT_EN
    // Once any carry has happened in this batch the sum stays pinned at max.
    acc_d   = ovf_d ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_d   = sum_ext[ACC_W-1:0];
`endif
  end

  // Batch FSM: gather COUNT beats in ACC, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (clear) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end else if (xfer) begin
            if (cnt_q == CNT_LAST) begin
              out_acc_q   <= acc_d;
              out_ovf_q   <= ovf_d;
              out_valid_q <= 1'b1;
              state_q     <= ST_HOLD;
              acc_q       <= '0;
              cnt_q       <= '0;
              ovf_q       <= 1'b0;
            end else begin
              acc_q <= acc_d;
              ovf_q <= ovf_d;
              cnt_q <= cnt_d;
            end
          end
        end
        ST_HOLD: begin
          // clear is deliberately ignored here: a finished result is never lost.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_ACC;
          end
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_mult_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_accumulator
//  Purpose  : Self-checking bench for mult_accumulator. Three instances
//             (COUNT = 4, 8, 1) share one stimulus stream and are compared
//             each cycle against a batch-level model built from true
//             integer sums.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_accumulator;

  localparam int ACC_W  = 10;
  localparam int PROD_W = 8;
  localparam int ACC_MAX = (1 << ACC_W) - 1;
  localparam int CNTS [3] = '{4, 8, 1};

  logic clk = 1'b0;
  logic rst, in_valid, clear, out_ready;
  logic [PROD_W-1:0] in_prod;

  logic [2:0] o_rdy, o_val, o_ovf, o_busy;
  logic [2:0][ACC_W-1:0] o_acc;

  int n_total = 0;
  int n_bad   = 0;

  // Batch-level model state per instance
  int m_sum  [3];
  int m_cnt  [3];
  bit m_hold [3];
  bit m_oval [3];
  bit m_oovf [3];
  int m_oacc [3];

  always #5 clk = ~clk;

  mult_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .COUNT(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_rdy[0]),
    .in_prod(in_prod), .clear(clear), .out_valid(o_val[0]),
    .out_ready(out_ready), .out_acc(o_acc[0]), .out_ovf(o_ovf[0]),
    .busy(o_busy[0]));

  mult_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .COUNT(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_rdy[1]),
    .in_prod(in_prod), .clear(clear), .out_valid(o_val[1]),
    .out_ready(out_ready), .out_acc(o_acc[1]), .out_ovf(o_ovf[1]),
    .busy(o_busy[1]));

  mult_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .COUNT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_rdy[2]),
    .in_prod(in_prod), .clear(clear), .out_valid(o_val[2]),
    .out_ready(out_ready), .out_acc(o_acc[2]), .out_ovf(o_ovf[2]),
    .busy(o_busy[2]));

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  function automatic int batch_result(input int total);
`ifdef MULT_ACCUMULATOR_SAT_EN
    return (total > ACC_MAX) ? ACC_MAX : total;
`else
    return total % (ACC_MAX + 1);
`endif
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_sum[k] = 0; m_cnt[k] = 0; m_hold[k] = 1'b0;
      m_oval[k] = 1'b0; m_oovf[k] = 1'b0; m_oacc[k] = 0;
    end
  endfunction

  // One clock: drive at negedge, check in_ready, advance model at posedge,
  // check registered outputs at the following negedge.
  task automatic cyc(input bit v, input int p, input bit c, input bit ordy, input bit rs);
    bit exp_rdy [3];
    in_valid = v; in_prod = PROD_W'(p); clear = c; out_ready = ordy; rst = rs;
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_rdy[k] = !m_hold[k] && !c;
      check($sformatf("in_ready[%0d]", k), int'(o_rdy[k]), int'(exp_rdy[k]));
    end
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m_hold[k]) begin
          if (ordy) begin m_oval[k] = 1'b0; m_hold[k] = 1'b0; end
        end else if (c) begin
          m_sum[k] = 0; m_cnt[k] = 0;
        end else if (v) begin
          m_sum[k] += p;
          m_cnt[k]++;
          if (m_cnt[k] == CNTS[k]) begin
            m_oacc[k] = batch_result(m_sum[k]);
            m_oovf[k] = (m_sum[k] > ACC_MAX);
            m_oval[k] = 1'b1;
            m_hold[k] = 1'b1;
            m_sum[k]  = 0;
            m_cnt[k]  = 0;
          end
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("out_valid[%0d]", k), int'(o_val[k]),  int'(m_oval[k]));
      check($sformatf("out_acc[%0d]", k),   int'(o_acc[k]),  m_oacc[k]);
      check($sformatf("out_ovf[%0d]", k),   int'(o_ovf[k]),  int'(m_oovf[k]));
      check($sformatf("busy[%0d]", k),      int'(o_busy[k]), int'(m_cnt[k] != 0));
    end
  endtask

  initial begin
    int pv, pp;
    in_valid = 1'b0; in_prod = '0; clear = 1'b0; out_ready = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset state
    cyc(0, 0, 0, 0, 1);
    check("rst_rdy",  int'(o_rdy),  3'b111);
    check("rst_val",  int'(o_val),  0);
    check("rst_acc0", int'(o_acc[0]), 0);

    // Basic batch: 4 x 225, result held with back-pressure
    for (int i = 0; i < 4; i++) cyc(1, 225, 0, 0, 0);
    check("basic_acc", int'(o_acc[0]), 900);
    check("basic_val", int'(o_val[0]), 1);
    check("basic_ovf", int'(o_ovf[0]), 0);
    for (int i = 0; i < 5; i++) cyc(1, 7, 0, 0, 0);
    check("bp_acc", int'(o_acc[0]), 900);
    cyc(1, 7, 0, 1, 0);
    check("bp_release", int'(o_val[0]), 0);
    check("bp_newbatch_busy", int'(o_busy[0]), 0);

    // Overflow on the COUNT=8 instance: 8 x 225 = 1800
    cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) cyc(1, 225, 0, 1, 0);
`ifdef MULT_ACCUMULATOR_SAT_EN
    check("ovf8_acc", int'(o_acc[1]), 1023);
`else
    check("ovf8_acc", int'(o_acc[1]), 776);
`endif
    check("ovf8_flag", int'(o_ovf[1]), 1);

    // Clear mid-batch, then 4 x 1
    cyc(0, 0, 0, 1, 1);
    cyc(1, 100, 0, 1, 0);
    cyc(1, 50, 0, 1, 0);
    cyc(1, 99, 1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 0);
    check("clr_acc", int'(o_acc[0]), 4);
    check("clr_busy", int'(o_busy[0]), 0);

    // Reset mid-batch and in HOLD, then 4 x 2
    cyc(1, 2, 0, 0, 0);
    cyc(1, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 9, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("rst_hold_val", int'(o_val[0]), 0);
    for (int i = 0; i < 4; i++) cyc(1, 2, 0, 0, 0);
    check("rst_batch_acc", int'(o_acc[0]), 8);

    // COUNT=1 gapped beats 3, 0, 255
    cyc(0, 0, 0, 1, 1);
    cyc(1, 3, 0, 1, 0);   check("c1_a", int'(o_acc[2]), 3);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);   check("c1_b_val", int'(o_val[2]), 1);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 255, 0, 1, 0); check("c1_c", int'(o_acc[2]), 255);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      pv = $urandom_range(99);
      pp = ($urandom_range(3) == 0) ? 255 - $urandom_range(30) : $urandom_range(255);
      cyc(pv < 70, pp, $urandom_range(99) < 5, $urandom_range(99) < 60,
          $urandom_range(199) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
